// File: rtl/shift_deser.sv
// ============================================================================
//  Module   : shift_deser
//  Brief    : Framed serial-to-parallel receiver (start/WIDTH data/stop) with
//             per-frame bit order, valid/ready output, framing and overrun flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module shift_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  input  logic             dir,
  output logic [WIDTH-1:0] Qout,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             ovr,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic             dir_q;
  logic [WIDTH-1:0] qout_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;
  logic             load_ok;

  // dir_q=0 fills from the LSB end (MSB-first); dir_q=1 fills from the MSB end.
  always_comb begin
    sh_d = sh_q;
    if (dir_q) sh_d = {sin, sh_q[WIDTH-1:1]};
    else       sh_d = {sh_q[WIDTH-2:0], sin};
  end

  assign load_ok = !valid_q || ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dir_q   <= 1'b0;
      qout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      // Accept clears valid; a load at the same edge below re-asserts it.
      if (valid_q && ready) valid_q <= 1'b0;
      if (en) begin
        case (state_q)
          S_IDLE: begin
            if (!sin) begin
              state_q <= S_DATA;
              cnt_q   <= '0;
              dir_q   <= dir;
            end
          end
          S_DATA: begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (!sin) begin
              ferr_q <= 1'b1;
            end else if (load_ok) begin
              qout_q  <= sh_q;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign Qout      = qout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign ovr       = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_deser.sv
// ============================================================================
//  Module   : tb_shift_deser
//  Brief    : Self-checking bench for shift_deser with an output-word scoreboard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_deser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr, en, sin, dir, ready;
  logic [W-1:0] Qout;
  logic         valid, frame_err, ovr, busy;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_w;

  always #5 clk = ~clk;

  shift_deser #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .sin       (sin),
    .dir       (dir),
    .Qout      (Qout),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .ovr       (ovr),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A word about to be accepted is compared with the oldest expected word.
  always @(negedge clk) begin
    if (!clr && valid && ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", 32'(Qout), 32'hFFFF_FFFF);
      end else begin
        exp_w = sb_q.pop_front();
        check("sb_word", 32'(Qout), 32'(exp_w));
      end
    end
  end

  // Gap cycles (en=0) precede the strobe; noisy gaps drive the wrong level.
  task automatic strobe(input logic b, input int gap, input logic noisy);
    for (int g = 0; g < gap; g++) begin
      en  = 1'b0;
      sin = noisy ? ~b : b;
      tick();
    end
    sin = b;
    en  = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic d, input logic stop,
                            input int gap, input logic noisy, input logic rdy_stop,
                            input logic exp_load, input logic exp_ovr);
    dir = d;
    strobe(1'b0, gap, noisy);
    dir = ~d;
    for (int i = 0; i < W; i++) strobe(d ? word[i] : word[W-1-i], gap, noisy);
    check("busy_in_frame", 32'(busy), 32'd1);
    ready = rdy_stop;
    if (exp_load) sb_q.push_back(word);
    strobe(stop, gap, noisy);
    check("frame_err_at_stop", 32'(frame_err), 32'(!stop));
    check("ovr_at_stop", 32'(ovr), 32'(exp_ovr));
    check("busy_after_stop", 32'(busy), 32'd0);
    if (exp_load) begin
      check("valid_after_load", 32'(valid), 32'd1);
      check("qout_after_load", 32'(Qout), 32'(word));
    end
  endtask

  task automatic idle_check(input logic exp_valid);
    sin = 1'b1;
    en  = 1'b1;
    tick();
    check("frame_err_one_cycle", 32'(frame_err), 32'd0);
    check("ovr_one_cycle", 32'(ovr), 32'd0);
    check("valid_idle", 32'(valid), 32'(exp_valid));
  endtask

  task automatic do_reset;
    clr = 1'b1; en = 1'b1; sin = 1'b0; ready = 1'b1;
    tick();
    tick();
    clr = 1'b0; sin = 1'b1;
    sb_q.delete();
    check("rst_qout", 32'(Qout), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1; en = 1'b0; sin = 1'b1; dir = 1'b0; ready = 1'b0;
    do_reset();

    // MSB-first, LSB-first on the same serial bits 1,0,1,1
    ready = 1'b1;
    send_frame(4'b1011, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t1_qout", 32'(Qout), 32'hB);
    idle_check(1'b0);
    send_frame(4'b1101, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t2_qout", 32'(Qout), 32'hD);
    idle_check(1'b0);

    // Framing error from a clean reset
    do_reset();
    send_frame(4'b1100, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_valid", 32'(valid), 32'd0);
    check("t3_qout", 32'(Qout), 32'd0);
    idle_check(1'b0);
    check("t3_busy", 32'(busy), 32'd0);

    // Overrun: first word held, second dropped
    ready = 1'b0;
    send_frame(4'b1011, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_qout_held", 32'(Qout), 32'hB);
    check("t4_valid_held", 32'(valid), 32'd1);
    idle_check(1'b1);
    ready = 1'b1;
    tick();
    check("t4_valid_cleared", 32'(valid), 32'd0);

    // Strobe gaps, held and noisy sin between strobes
    send_frame(4'b1011, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_qout", 32'(Qout), 32'hB);
    idle_check(1'b0);
    send_frame(4'b0110, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_check(1'b0);

    // Reset mid-frame, then a full frame
    dir = 1'b0;
    strobe(1'b0, 0, 1'b0);
    strobe(1'b1, 0, 1'b0);
    strobe(1'b0, 0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sin = 1'b1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_qout", 32'(Qout), 32'd0);
    send_frame(4'b0101, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_qout_after", 32'(Qout), 32'h5);
    idle_check(1'b0);

    // Back-to-back frames with no idle between stop and start
    send_frame(4'b1001, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(4'b0011, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_check(1'b0);

    // Accept of the held word coincides with the next load
    ready = 1'b0;
    send_frame(4'b1110, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(4'b0100, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("acc_load_valid", 32'(valid), 32'd1);
    idle_check(1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
